// File: rtl/fifo_32x32_ctrl.sv
// fifo_32x32_ctrl: 32-entry x 32-bit FIFO controller driving an external
// dual-port SRAM with an asynchronous read port. It keeps the pointers,
// occupancy and sticky error flags. The storage itself lives in the macro.
module fifo_32x32_ctrl #(
  parameter int unsigned ALMOST_FULL_LEVEL = 28
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        clear,
  input  logic        push,
  input  logic [31:0] pushData,
  input  logic        pop,
  output logic [31:0] popData,
  output logic        full,
  output logic        empty,
  output logic        almostFull,
  output logic [5:0]  fillLevel,
  output logic        overflow,
  output logic        underflow,
  output logic        memWriteEnable,
  output logic [4:0]  memWriteAddress,
  output logic [31:0] memWriteData,
  output logic [4:0]  memReadAddress,
  input  logic [31:0] memReadData
);

  localparam int unsigned DEPTH  = 32;
  localparam logic [5:0]  AF_LVL = 6'(ALMOST_FULL_LEVEL);
  localparam logic [5:0]  FULL_C = 6'(DEPTH);

  logic [4:0] wr_ptr_q, wr_ptr_d;
  logic [4:0] rd_ptr_q, rd_ptr_d;
  logic [5:0] count_q,  count_d;
  logic       ovf_q,    ovf_d;
  logic       udf_q,    udf_d;

  logic       full_w, empty_w;
  logic       push_acc, pop_acc;

  // Status is decoded from the registered count only, so push/pop never
  // reach these flags combinationally.
  assign full_w     = (count_q == FULL_C);
  assign empty_w    = (count_q == 6'd0);
  assign full       = full_w;
  assign empty      = empty_w;
  assign almostFull = (count_q >= AF_LVL);
  assign fillLevel  = count_q;
  assign overflow   = ovf_q;
  assign underflow  = udf_q;

  // A push into a full FIFO is legal only when a pop frees the head slot in
  // the same cycle. There is no fall-through: a pop on empty is always
  // rejected, even with a simultaneous push.
  assign push_acc = push & ~clear & (~full_w | pop);
  assign pop_acc  = pop  & ~clear & ~empty_w;

  // SRAM port wiring. When full with push+pop, both addresses are the same.
  // The asynchronous read returns the old head before the write lands.
  assign memWriteEnable  = push_acc;
  assign memWriteAddress = wr_ptr_q;
  assign memWriteData    = pushData;
  assign memReadAddress  = rd_ptr_q;
  assign popData         = memReadData;

  // Next-state: pointers wrap naturally at 5 bits, count tracks net change,
  // and clear flushes everything except the SRAM contents.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    udf_d    = udf_q;
    if (clear) begin
      wr_ptr_d = 5'd0;
      rd_ptr_d = 5'd0;
      count_d  = 6'd0;
      ovf_d    = 1'b0;
      udf_d    = 1'b0;
    end else begin
      if (push_acc) wr_ptr_d = wr_ptr_q + 5'd1;
      if (pop_acc)  rd_ptr_d = rd_ptr_q + 5'd1;
      case ({push_acc, pop_acc})
        2'b10:   count_d = count_q + 6'd1;
        2'b01:   count_d = count_q - 6'd1;
        default: count_d = count_q;
      endcase
      if (push & full_w & ~pop) ovf_d = 1'b1;
      if (pop & empty_w)        udf_d = 1'b1;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= 5'd0;
      rd_ptr_q <= 5'd0;
      count_q  <= 6'd0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

endmodule

// File: doc/fifo_32x32_ctrl.md
# fifo_32x32_ctrl

Synchronous 32-entry, 32-bit FIFO controller that drives the write port and read address of the 32x32 dual-port, asynchronous-read SRAM macro. It feeds the macro and consumes its read data. It provides push/pop handshakes, occupancy tracking, almost-full and error flags, and a synchronous flush. It sits between a producer (e.g. DMA or bus bridge) and a consumer in the virtual prototype. The SRAM is instantiated outside this block, and its ports are wired to the `mem*` ports.

## Interface
Parameters:
- `ALMOST_FULL_LEVEL`, default 28, occupancy at or above which `almostFull` asserts; legal range 1..32.

Ports:
- `clock`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `clear`  in  1  synchronous flush; priority over push/pop.
- `push`  in  1  write request.
- `pushData`  in  32  data to write.
- `pop`  in  1  read request.
- `popData`  out  32  head-of-FIFO data; valid when `empty`=0.
- `full`  out  1  occupancy == 32.
- `empty`  out  1  occupancy == 0.
- `almostFull`  out  1  occupancy >= `ALMOST_FULL_LEVEL`.
- `fillLevel`  out  6  occupancy, 0..32.
- `overflow`  out  1  sticky: a push was rejected.
- `underflow`  out  1  sticky: a pop was rejected.
- `memWriteEnable`  out  1  to SRAM `writeEnable`.
- `memWriteAddress`  out  5  to SRAM `writeAddress`.
- `memWriteData`  out  32  to SRAM `writeData`.
- `memReadAddress`  out  5  to SRAM `readAddress`.
- `memReadData`  in  32  from SRAM `dataReadPort` (combinational).

## Operation
- State:
  - `writePtr` is 5 bits.
  - `readPtr` is 5 bits.
  - `count` is 6 bits.
  - The `overflow` and `underflow` flags are registered.
- Pointers wrap naturally from 31 to 0.
- `pushAccept = push & ~clear & (~full | pop)`. A push while full is accepted only when it coincides with a pop.
- `popAccept = pop & ~clear & ~empty`. There is no fall-through. A pop while empty is rejected even with a simultaneous push.
- Combinational outputs:
  - `memWriteEnable = pushAccept`
  - `memWriteAddress = writePtr`
  - `memWriteData = pushData`
  - `memReadAddress = readPtr`
  - `popData = memReadData`
- On a rising edge:
  - If `pushAccept`, `writePtr` is incremented.
  - If `popAccept`, `readPtr` is incremented.
  - `count` changes by +1 (push only), -1 (pop only), or 0 (both or neither).
- Flags:
  - `overflow` is set on `push & ~clear & full & ~pop`.
  - `underflow` is set on `pop & ~clear & empty`.
  - Both flags stay set until `clear` or `reset`.
- `clear`: pointers, `count`, `overflow` and `underflow` all go to 0 on the next edge. `memWriteEnable` is 0 during the `clear` cycle. SRAM contents are untouched.
- `full`, `empty`, `almostFull` and `fillLevel` derive from registered `count` only. There is no combinational path from `push`/`pop` to them.

## Timing
- Reset (asynchronous, immediate) output values:
  - `empty`=1
  - `full`=0
  - `almostFull`=0
  - `fillLevel`=0
  - `overflow`=0
  - `underflow`=0
  - `memWriteEnable`=0
  - `memWriteAddress`=0
  - `memReadAddress`=0
- `popData` is undefined until the first write.
- Write-to-read latency is 1 cycle:
  - A push accepted at edge N makes `empty`=0 from N.
  - `popData` shows that word in the cycle after N.
- A pop consumes `popData` presented in the same cycle. The next word appears after the edge.
- Push and pop when full: the read returns the old head before the edge. The write lands at the same address at the edge, which is safe because the SRAM read is asynchronous. `count` stays 32.
- Push and pop when empty: only the push is accepted, `underflow` is set, and `count` becomes 1.
- Reset mid-operation discards all contents logically. Pointers return to 0.

## Test plan
- Reset, then push 0x00000001..0x00000020 on 32 consecutive cycles. Required: `full`=1, `fillLevel`=32, `almostFull` asserted after the 28th push, `overflow`=0.
- From full, pop 32 times. Required: `popData` sequence is 0x00000001..0x00000020, then `empty`=1 and `fillLevel`=0.
- Fill to 32, push 0xDEADBEEF without pop. Required: rejected, `memWriteEnable`=0, `overflow`=1 sticky. Then assert `clear` for 1 cycle. Required: `overflow`=0, `empty`=1.
- At `fillLevel`=32, push 0xA5A5A5A5 and pop in the same cycle. Required: pop returns the oldest word, `fillLevel` stays 32. After 31 more pops, `popData`=0xA5A5A5A5.
- On an empty FIFO, push 0x12345678 and pop in the same cycle. Required: `underflow`=1, `fillLevel`=1, next-cycle `popData`=0x12345678.
- Push 40 times with interleaved pops to wrap the pointers past 31→0. Required: data order preserved. Assert `reset` mid-burst. Required: outputs immediately at reset values.
